// File: rtl/rf_writeback_queue_if.sv
// Writeback request channels (memory-load and ALU producers) into rf_writeback_queue.
// The master modport is the producer side; the slave modport is the queue side.
interface rf_writeback_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              MEM_VALID;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DATA;
    logic              MEM_READY;
    logic              ALU_VALID;
    logic [ADDR_W-1:0] ALU_ADDR;
    logic [DATA_W-1:0] ALU_DATA;
    logic              ALU_READY;

    modport master (
        output MEM_VALID, MEM_ADDR, MEM_DATA, input MEM_READY,
        output ALU_VALID, ALU_ADDR, ALU_DATA, input ALU_READY
    );

    modport slave (
        input MEM_VALID, MEM_ADDR, MEM_DATA, output MEM_READY,
        input ALU_VALID, ALU_ADDR, ALU_DATA, output ALU_READY
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Two-producer writeback arbiter + in-order FIFO feeding the register file write port,
// with a hazard query port. Optional macro RF_WB_BYPASS_EN enables CHK_DATA forwarding.
module rf_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    rf_writeback_queue_if.slave    req,
    input  logic                   RF_HOLD,
    output logic                   WRITE_ENABLE,
    output logic [ADDR_W-1:0]      ADDRESS_WRITE,
    output logic [DATA_W-1:0]      DATA_WRITE,
    input  logic [ADDR_W-1:0]      CHK_ADDR,
    output logic                   CHK_PENDING,
    output logic [DATA_W-1:0]      CHK_DATA,
    output logic [$clog2(DEPTH):0] COUNT
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              write_enable_r;
    logic [ADDR_W-1:0] address_write_r;
    logic [DATA_W-1:0] data_write_r;

    logic              full_s;
    logic              mem_acc_s;
    logic              alu_acc_s;
    logic              enq_s;
    logic              deq_s;
    logic [ADDR_W-1:0] enq_addr_s;
    logic [DATA_W-1:0] enq_data_s;
    logic [DEPTH-1:0]  match_s;
    logic              reg_match_s;
    logic [DATA_W-1:0] byp_data_s;

    // Full blocks enqueue even when a pop happens on the same edge.
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign mem_acc_s  = req.MEM_VALID & ~full_s;
    assign alu_acc_s  = req.ALU_VALID & ~full_s & ~req.MEM_VALID;
    assign enq_s      = mem_acc_s | alu_acc_s;
    assign deq_s      = ~RF_HOLD & (count_r != CNT_W'(0));
    assign enq_addr_s = mem_acc_s ? req.MEM_ADDR : req.ALU_ADDR;
    assign enq_data_s = mem_acc_s ? req.MEM_DATA : req.ALU_DATA;

    assign req.MEM_READY = ~full_s;
    assign req.ALU_READY = ~full_s & ~req.MEM_VALID;

    assign WRITE_ENABLE  = write_enable_r;
    assign ADDRESS_WRITE = address_write_r;
    assign DATA_WRITE    = data_write_r;
    assign COUNT         = count_r;

    // FIFO storage; flushing is done through the pointers, so no reset here.
    always_ff @(posedge CLK) begin
        if (enq_s) begin
            addr_mem_r[wr_ptr_r] <= enq_addr_s;
            data_mem_r[wr_ptr_r] <= enq_data_s;
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_r        <= PTR_W'(0);
            wr_ptr_r        <= PTR_W'(0);
            count_r         <= CNT_W'(0);
            write_enable_r  <= 1'b0;
            address_write_r <= ADDR_W'(0);
            data_write_r    <= DATA_W'(0);
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (deq_s) begin
                write_enable_r  <= 1'b1;
                address_write_r <= addr_mem_r[rd_ptr_r];
                data_write_r    <= data_mem_r[rd_ptr_r];
                rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
            end else begin
                write_enable_r  <= 1'b0;
            end
        end
    end

    // Per-entry address match, indexed by age (bit 0 = oldest queued entry).
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = (CNT_W'(k) < count_r) &&
                         (addr_mem_r[rd_ptr_r + PTR_W'(k)] == CHK_ADDR);
        end
    end

    assign reg_match_s = write_enable_r & (address_write_r == CHK_ADDR);
    assign CHK_PENDING = reg_match_s | (|match_s);

`ifdef RF_WB_BYPASS_EN
    // Youngest match wins: walk from the issuing register through oldest to newest entry.
    always_comb begin
        byp_data_s = reg_match_s ? data_write_r : DATA_W'(0);
        for (int k = 0; k < DEPTH; k++) begin
            byp_data_s = match_s[k] ? data_mem_r[rd_ptr_r + PTR_W'(k)] : byp_data_s;
        end
    end
`else
    assign byp_data_s = DATA_W'(0);
`endif

    assign CHK_DATA = byp_data_s;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized + directed bench for rf_writeback_queue: a queue-based reference model
// predicts readiness/occupancy/hazards, and a scoreboard checks every issued write.
module tb_rf_writeback_queue;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          RF_HOLD;
    logic          WRITE_ENABLE;
    logic [AW-1:0] ADDRESS_WRITE;
    logic [DW-1:0] DATA_WRITE;
    logic [AW-1:0] CHK_ADDR;
    logic          CHK_PENDING;
    logic [DW-1:0] CHK_DATA;
    logic [2:0]    COUNT;

    always #5 CLK = ~CLK;

    rf_writeback_queue_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rf_writeback_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .req(bus), .RF_HOLD(RF_HOLD),
        .WRITE_ENABLE(WRITE_ENABLE), .ADDRESS_WRITE(ADDRESS_WRITE), .DATA_WRITE(DATA_WRITE),
        .CHK_ADDR(CHK_ADDR), .CHK_PENDING(CHK_PENDING), .CHK_DATA(CHK_DATA), .COUNT(COUNT)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    int      tests_run    = 0;
    int      tests_failed = 0;
    ent_t    model_q[$];
    ent_t    sb_q[$];
    logic    m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit      check_en = 1'b0;
    bit      mem_acc;
    bit      alu_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every issued write must be the oldest accepted request.
    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            if (check_en && WRITE_ENABLE === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             ADDRESS_WRITE, DATA_WRITE);
                end else begin
                    e = sb_q.pop_front();
                    check("wb_addr", ADDRESS_WRITE, e.a);
                    check("wb_data", DATA_WRITE, e.d);
                end
            end
        end
    end

    // One clock: check DUT against the model, then advance the model across the next edge.
    task automatic step();
        bit            full;
        bit            pop;
        logic          exp_pend;
        logic [DW-1:0] exp_data;
        ent_t          e;
        @(negedge CLK);
        #1;
        full = (model_q.size() == DEPTH);
        if (check_en) begin
            check("count", COUNT, model_q.size());
            check("we", WRITE_ENABLE, m_we);
            check("addr_hold", ADDRESS_WRITE, m_addr);
            check("data_hold", DATA_WRITE, m_data);
            check("mem_ready", bus.MEM_READY, !full);
            check("alu_ready", bus.ALU_READY, !full && !bus.MEM_VALID);
            exp_pend = m_we && (m_addr == CHK_ADDR);
            exp_data = exp_pend ? m_data : 32'h0;
            foreach (model_q[i]) begin
                if (model_q[i].a == CHK_ADDR) begin
                    exp_pend = 1'b1;
                    exp_data = model_q[i].d;
                end
            end
`ifndef RF_WB_BYPASS_EN
            exp_data = 32'h0;
`endif
            check("chk_pending", CHK_PENDING, exp_pend);
            check("chk_data", CHK_DATA, exp_data);
        end
        if (RESET) begin
            model_q.delete();
            sb_q.delete();
            m_we    = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            mem_acc = 1'b0;
            alu_acc = 1'b0;
        end else begin
            mem_acc = bus.MEM_VALID && !full;
            alu_acc = bus.ALU_VALID && !full && !bus.MEM_VALID;
            pop     = !RF_HOLD && (model_q.size() > 0);
            if (pop) begin
                e      = model_q.pop_front();
                m_we   = 1'b1;
                m_addr = e.a;
                m_data = e.d;
            end else begin
                m_we   = 1'b0;
            end
            if (mem_acc) begin
                e.a = bus.MEM_ADDR;
                e.d = bus.MEM_DATA;
                model_q.push_back(e);
                sb_q.push_back(e);
            end else if (alu_acc) begin
                e.a = bus.ALU_ADDR;
                e.d = bus.ALU_DATA;
                model_q.push_back(e);
                sb_q.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.MEM_VALID = 1'b1;
        bus.MEM_ADDR  = a;
        bus.MEM_DATA  = d;
        for (int n = 0; n < 20; n++) begin
            step();
            if (mem_acc) break;
        end
        check("push_accept", mem_acc, 1'b1);
        bus.MEM_VALID = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; RF_HOLD = 1'b0; CHK_ADDR = '0;
        bus.MEM_VALID = 1'b0; bus.MEM_ADDR = '0; bus.MEM_DATA = '0;
        bus.ALU_VALID = 1'b0; bus.ALU_ADDR = '0; bus.ALU_DATA = '0;

        // Reset held two edges with a load request pending.
        step();
        check_en = 1'b1;
        bus.MEM_VALID = 1'b1; bus.MEM_ADDR = 5'd9; bus.MEM_DATA = 32'h1234;
        step();
        RESET = 1'b0; bus.MEM_VALID = 1'b0;
        check("rst_count", COUNT, 3'd0);
        check("rst_we", WRITE_ENABLE, 1'b0);
        check("rst_addr", ADDRESS_WRITE, 5'd0);
        check("rst_data", DATA_WRITE, 32'h0);
        step();

        // Single load into empty queue.
        push_mem(5'd3, 32'hDEADBEEF);
        step();
        check("lat_we", WRITE_ENABLE, 1'b1);
        check("lat_addr", ADDRESS_WRITE, 5'd3);
        check("lat_data", DATA_WRITE, 32'hDEADBEEF);
        repeat (2) step();

        // MEM beats ALU in the same cycle.
        bus.MEM_VALID = 1'b1; bus.MEM_ADDR = 5'd1; bus.MEM_DATA = 32'h11;
        bus.ALU_VALID = 1'b1; bus.ALU_ADDR = 5'd2; bus.ALU_DATA = 32'h22;
        step();
        bus.MEM_VALID = 1'b0;
        step();
        bus.ALU_VALID = 1'b0;
        repeat (3) step();

        // Fill under hold, fifth request back-pressured, then drain.
        RF_HOLD = 1'b1;
        for (int i = 0; i < 4; i++) push_mem(AW'(10 + i), DW'(32'hA0 + i));
        bus.MEM_VALID = 1'b1; bus.MEM_ADDR = 5'd14; bus.MEM_DATA = 32'hA4;
        repeat (3) step();
        check("full_count", COUNT, 3'd4);
        check("full_ready", bus.MEM_READY, 1'b0);
        RF_HOLD = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (mem_acc) break;
        end
        check("fifth_accept", mem_acc, 1'b1);
        bus.MEM_VALID = 1'b0;
        repeat (8) step();

        // Hazard query with two queued writes to r7.
        RF_HOLD = 1'b1;
        push_mem(5'd7, 32'h1);
        push_mem(5'd7, 32'h2);
        CHK_ADDR = 5'd7;
        #1;
        check("haz7_pending", CHK_PENDING, 1'b1);
`ifdef RF_WB_BYPASS_EN
        check("haz7_data", CHK_DATA, 32'h2);
`else
        check("haz7_data", CHK_DATA, 32'h0);
`endif
        CHK_ADDR = 5'd8;
        #1;
        check("haz8_pending", CHK_PENDING, 1'b0);
        step();
        RF_HOLD = 1'b0;
        repeat (6) step();

        // Reset in the middle of a drain.
        RF_HOLD = 1'b1;
        for (int i = 0; i < 4; i++) push_mem(AW'(20 + i), DW'(32'hB0 + i));
        RF_HOLD = 1'b0;
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_we", WRITE_ENABLE, 1'b0);
        check("mid_rst_count", COUNT, 3'd0);
        repeat (5) step();

        // Randomized traffic with hold, hazard queries and occasional reset.
        for (int c = 0; c < 800; c++) begin
            if (!bus.MEM_VALID && $urandom_range(0, 2) == 0) begin
                bus.MEM_VALID = 1'b1;
                bus.MEM_ADDR  = AW'($urandom_range(0, 7));
                bus.MEM_DATA  = $urandom;
            end
            if (!bus.ALU_VALID && $urandom_range(0, 1) == 0) begin
                bus.ALU_VALID = 1'b1;
                bus.ALU_ADDR  = AW'($urandom_range(0, 7));
                bus.ALU_DATA  = $urandom;
            end
            RF_HOLD  = ($urandom_range(0, 3) == 0);
            CHK_ADDR = AW'($urandom_range(0, 7));
            RESET    = ($urandom_range(0, 199) == 0);
            step();
            if (mem_acc || RESET) bus.MEM_VALID = 1'b0;
            if (alu_acc || RESET) bus.ALU_VALID = 1'b0;
            RESET = 1'b0;
        end

        bus.MEM_VALID = 1'b0; bus.ALU_VALID = 1'b0; RF_HOLD = 1'b0;
        repeat (8) step();
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
